// File: rtl/compute_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// compute_ctrl_pkg
// Shared types for the digit-serial SIMD MAC compute controller:
//   ctrl_e    - datapath command codes driven on ctrl
//   state_e   - controller FSM states
//   sel_width - index width for n items, never narrower than one bit
// -----------------------------------------------------------------------------
package compute_ctrl_pkg;

   typedef enum logic [2:0] {
      CTRL_NOP       = 3'd0,
      CTRL_LOAD      = 3'd1,
      CTRL_NEXT_PAIR = 3'd2,
      CTRL_NEXT_A    = 3'd3,  // advance a-digit, rewind w-digit
      CTRL_NEXT_W    = 3'd4
   } ctrl_e;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_COMPUTE,
      ST_STALL
   } state_e;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/compute_ctrl_mb_acc_bank_tracker.sv
// -----------------------------------------------------------------------------
// acc_bank_tracker
// Rotates the active accumulator bank and tracks committed banks awaiting drain.
//   clk, rst    - clock, synchronous active-low reset
//   commit      - close the active bank this cycle and move to the next one
//   drain_ack   - downstream consumed drain_bank (ignored when nothing pending)
//   acc_sel     - active accumulator bank
//   drain_req   - at least one committed bank awaits drain
//   drain_bank  - oldest committed bank
//   full        - every bank is committed right now
//   full_next   - every bank will be committed after this cycle's commit/ack
// -----------------------------------------------------------------------------
module acc_bank_tracker
   import compute_ctrl_pkg::*;
#(
   parameter int NUM_ACC = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           commit,
   input  logic                           drain_ack,
   output logic [sel_width(NUM_ACC)-1:0]  acc_sel,
   output logic                           drain_req,
   output logic [sel_width(NUM_ACC)-1:0]  drain_bank,
   output logic                           full,
   output logic                           full_next
);

   localparam int SEL_W  = sel_width(NUM_ACC);
   localparam int PEND_W = $clog2(NUM_ACC + 1);

   logic [PEND_W-1:0] pending, pending_n;
   logic [SEL_W-1:0]  acc_sel_n;
   logic              take;
   logic [31:0]       diff;

   assign drain_req = (pending != '0);
   assign take      = drain_ack & drain_req;
   assign full      = (pending == PEND_W'(NUM_ACC));
   assign full_next = (pending_n == PEND_W'(NUM_ACC));

   // NOTE: every variable driven here gets a default first, so no path can
   // leave it holding its old value and infer a latch.
   always_comb begin
      pending_n = pending;
      acc_sel_n = acc_sel;
      // A commit and an ack in the same cycle cancel out.
      if (commit && !take)
         pending_n = pending + PEND_W'(1);
      else if (take && !commit)
         pending_n = pending - PEND_W'(1);
      if (commit)
         acc_sel_n = (acc_sel == SEL_W'(NUM_ACC - 1)) ? '0 : acc_sel + SEL_W'(1);
   end

   // Oldest committed bank = (acc_sel - pending) mod NUM_ACC; NUM_ACC need not
   // be a power of two, so the wrap is done explicitly.
   always_comb begin
      diff = 32'(acc_sel) + 32'(NUM_ACC) - 32'(pending);
      if (diff >= 32'(NUM_ACC))
         diff = diff - 32'(NUM_ACC);
      drain_bank = SEL_W'(diff);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= '0;
         acc_sel <= '0;
      end else begin
         pending <= pending_n;
         acc_sel <= acc_sel_n;
      end
   end

endmodule

// File: rtl/compute_ctrl_mb.sv
// -----------------------------------------------------------------------------
// compute_ctrl_mb
// PE compute controller: loads SIMD activation/weight pairs per group (optionally
// storing only nonzero-product pairs), walks the a-digit x w-digit loop for each
// stored pair, and rotates results across NUM_ACC accumulator banks drained by
// a req/ack handshake.
//   clk, rst        - clock, synchronous active-low reset
//   aw_valid/ready  - input pair handshake
//   eow             - end of window, qualified by the accepted beat
//   nz, skip_en     - pair has nonzero product / store only such pairs
//   a_last, w_last  - current digit is the last nonzero digit
//   ctrl            - datapath command (ctrl_e)
//   compute_write   - accumulate current partial product
//   acc_sel         - active accumulator bank
//   drain_req/bank  - oldest committed bank awaiting drain
//   drain_ack       - downstream consumed drain_bank
// -----------------------------------------------------------------------------
module compute_ctrl_mb
   import compute_ctrl_pkg::*;
#(
   parameter int SIMD     = 4,
   parameter int A_DIGITS = 4,
   parameter int W_DIGITS = 4,
   parameter int NUM_ACC  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           aw_valid,
   output logic                           aw_ready,
   input  logic                           eow,
   input  logic                           nz,
   input  logic                           skip_en,
   input  logic                           a_last,
   input  logic                           w_last,
   output logic [2:0]                     ctrl,
   output logic                           compute_write,
   output logic [sel_width(NUM_ACC)-1:0]  acc_sel,
   output logic                           drain_req,
   output logic [sel_width(NUM_ACC)-1:0]  drain_bank,
   input  logic                           drain_ack
);

   localparam int SLOT_W = sel_width(SIMD);
   localparam int CNT_W  = $clog2(SIMD + 1);   // nz_cnt reaches SIMD
   localparam int A_W    = sel_width(A_DIGITS);
   localparam int W_W    = sel_width(W_DIGITS);

   state_e              state, state_n;
   ctrl_e               ctrl_c;
   logic [SLOT_W-1:0]   slot, slot_n;
   logic [CNT_W-1:0]    nz_cnt, nz_n, pair_cnt, pair_n;
   logic [A_W-1:0]      a_cnt, a_n;
   logic [W_W-1:0]      w_cnt, w_n;
   logic                eow_flag, eow_n;
   logic                commit, full, full_next;
   logic                accept, store, a_end, w_end;

   assign ctrl  = ctrl_c;
   // The digit caps end the loop even if the last-digit flags never arrive.
   assign a_end = a_last | (a_cnt == A_W'(A_DIGITS - 1));
   assign w_end = w_last | (w_cnt == W_W'(W_DIGITS - 1));
   assign store = nz | ~skip_en;

   always_comb begin
      state_n       = state;
      slot_n        = slot;
      nz_n          = nz_cnt;
      pair_n        = pair_cnt;
      a_n           = a_cnt;
      w_n           = w_cnt;
      eow_n         = eow_flag;
      ctrl_c        = CTRL_NOP;
      compute_write = 1'b0;
      aw_ready      = 1'b0;
      accept        = 1'b0;
      commit        = 1'b0;

      case (state)
         ST_LOAD: begin
            aw_ready = ~full;
            accept   = aw_valid & ~full;
            if (accept) begin
               if (store) begin
                  ctrl_c = CTRL_LOAD;
                  nz_n   = nz_cnt + CNT_W'(1);
               end
               eow_n = eow_flag | eow;
               if (slot == SLOT_W'(SIMD - 1)) begin
                  slot_n = '0;
                  if (nz_n != '0) begin
                     state_n = ST_COMPUTE;
                  end else if (eow_flag | eow) begin
                     // Window with nothing to compute still closes its bank.
                     commit = 1'b1;
                     eow_n  = 1'b0;
                  end
               end else begin
                  slot_n = slot + SLOT_W'(1);
               end
            end
         end

         ST_COMPUTE: begin
            compute_write = 1'b1;
            if (!w_end) begin
               ctrl_c = CTRL_NEXT_W;
               w_n    = w_cnt + W_W'(1);
            end else if (!a_end) begin
               ctrl_c = CTRL_NEXT_A;
               a_n    = a_cnt + A_W'(1);
               w_n    = '0;
            end else begin
               ctrl_c = CTRL_NEXT_PAIR;
               a_n    = '0;
               w_n    = '0;
               if (pair_cnt + CNT_W'(1) == nz_cnt) begin
                  pair_n = '0;
                  nz_n   = '0;
                  if (eow_flag) begin
                     commit = 1'b1;
                     eow_n  = 1'b0;
                  end
                  state_n = full_next ? ST_STALL : ST_LOAD;
               end else begin
                  pair_n = pair_cnt + CNT_W'(1);
               end
            end
         end

         ST_STALL: begin
            // Leave as soon as this cycle's ack frees a bank.
            if (!full_next)
               state_n = ST_LOAD;
         end

         default: state_n = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_LOAD;
         slot     <= '0;
         nz_cnt   <= '0;
         pair_cnt <= '0;
         a_cnt    <= '0;
         w_cnt    <= '0;
         eow_flag <= 1'b0;
      end else begin
         state    <= state_n;
         slot     <= slot_n;
         nz_cnt   <= nz_n;
         pair_cnt <= pair_n;
         a_cnt    <= a_n;
         w_cnt    <= w_n;
         eow_flag <= eow_n;
      end
   end

   acc_bank_tracker #(
      .NUM_ACC (NUM_ACC)
   ) u_banks (
      .clk        (clk),
      .rst        (rst),
      .commit     (commit),
      .drain_ack  (drain_ack),
      .acc_sel    (acc_sel),
      .drain_req  (drain_req),
      .drain_bank (drain_bank),
      .full       (full),
      .full_next  (full_next)
   );

endmodule

// File: tb/tb_compute_ctrl_mb.sv
// -----------------------------------------------------------------------------
// tb_compute_ctrl_mb
// Self-checking bench for compute_ctrl_mb. Directed scenarios plus randomized
// windows checked against a window/pair-level model: committed banks are kept
// in a FIFO whose head is the expected drain_bank, and expected ctrl codes come
// from nested digit loops over per-pair digit counts chosen by the bench.
// -----------------------------------------------------------------------------
module tb_compute_ctrl_mb;

   localparam int SIMD     = 4;
   localparam int A_DIGITS = 4;
   localparam int W_DIGITS = 4;
   localparam int NUM_ACC  = 2;
   localparam int SEL_W    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             aw_valid = 1'b0, eow = 1'b0, nz = 1'b0, skip_en = 1'b0;
   logic             a_last = 1'b0, w_last = 1'b0, drain_ack = 1'b0;
   logic             aw_ready, compute_write, drain_req;
   logic [2:0]       ctrl;
   logic [SEL_W-1:0] acc_sel, drain_bank;

   int vec  = 0;
   int miss = 0;

   // Model: active bank and FIFO of committed banks (oldest first).
   int m_acc_sel = 0;
   int bank_q[$];

   compute_ctrl_mb #(
      .SIMD     (SIMD),
      .A_DIGITS (A_DIGITS),
      .W_DIGITS (W_DIGITS),
      .NUM_ACC  (NUM_ACC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .aw_valid      (aw_valid),
      .aw_ready      (aw_ready),
      .eow           (eow),
      .nz            (nz),
      .skip_en       (skip_en),
      .a_last        (a_last),
      .w_last        (w_last),
      .ctrl          (ctrl),
      .compute_write (compute_write),
      .acc_sel       (acc_sel),
      .drain_req     (drain_req),
      .drain_bank    (drain_bank),
      .drain_ack     (drain_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Inputs change on the falling edge; outputs are sampled 1ns later,
   // well before the next rising edge.
   task automatic drive(input bit v, input bit n, input bit e, input bit s,
                        input bit al, input bit wl, input bit ack);
      @(negedge clk);
      aw_valid = v; nz = n; eow = e; skip_en = s;
      a_last = al; w_last = wl; drain_ack = ack;
      #1;
   endtask

   task automatic m_commit();
      bank_q.push_back(m_acc_sel);
      m_acc_sel = (m_acc_sel + 1) % NUM_ACC;
   endtask

   task automatic m_ack();
      if (bank_q.size() != 0) void'(bank_q.pop_front());
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      m_acc_sel = 0;
      bank_q.delete();
      vec++; if (ctrl !== 3'd0) begin miss++; $display("FAIL reset_ctrl: got %0d want 0", ctrl); end
      vec++; if (compute_write !== 1'b0) begin miss++; $display("FAIL reset_cw: got %b want 0", compute_write); end
      vec++; if (aw_ready !== 1'b1) begin miss++; $display("FAIL reset_ready: got %b want 1", aw_ready); end
      vec++; if (drain_req !== 1'b0) begin miss++; $display("FAIL reset_drain_req: got %b want 0", drain_req); end
      vec++; if (drain_bank !== '0) begin miss++; $display("FAIL reset_drain_bank: got %0d want 0", drain_bank); end
      vec++; if (acc_sel !== '0) begin miss++; $display("FAIL reset_acc_sel: got %0d want 0", acc_sel); end
   endtask

   task automatic test_dense();
      for (int i = 0; i < SIMD; i++) begin
         drive(1, 1'($urandom), 0, 0, 1, 1, 0);
         vec++;
         if (aw_ready !== 1'b1 || ctrl !== 3'd1 || compute_write !== 1'b0) begin
            miss++; $display("FAIL dense_load[%0d]: ready=%b ctrl=%0d cw=%b want 1/1/0", i, aw_ready, ctrl, compute_write);
         end
      end
      for (int i = 0; i < SIMD; i++) begin
         drive(1, 1'($urandom), 0, 0, 1, 1, 0);
         vec++;
         if (aw_ready !== 1'b0 || ctrl !== 3'd2 || compute_write !== 1'b1) begin
            miss++; $display("FAIL dense_compute[%0d]: ready=%b ctrl=%0d cw=%b want 0/2/1", i, aw_ready, ctrl, compute_write);
         end
      end
      drive(0, 0, 0, 0, 1, 1, 0);
      vec++;
      if (aw_ready !== 1'b1 || ctrl !== 3'd0 || compute_write !== 1'b0) begin
         miss++; $display("FAIL dense_back_to_load: ready=%b ctrl=%0d cw=%b want 1/0/0", aw_ready, ctrl, compute_write);
      end
   endtask

   task automatic test_skip();
      bit [3:0] pat = 4'b1001;  // beat i uses pat[i]
      for (int i = 0; i < SIMD; i++) begin
         drive(1, pat[i], 0, 1, 1, 1, 0);
         vec++;
         if (ctrl !== (pat[i] ? 3'd1 : 3'd0)) begin
            miss++; $display("FAIL skip_load[%0d]: ctrl=%0d want %0d", i, ctrl, pat[i]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, 1, 1, 0);
         vec++;
         if (ctrl !== 3'd2 || compute_write !== 1'b1) begin
            miss++; $display("FAIL skip_compute[%0d]: ctrl=%0d cw=%b want 2/1", i, ctrl, compute_write);
         end
      end
      drive(0, 0, 0, 1, 1, 1, 0);
      vec++;
      if (compute_write !== 1'b0 || aw_ready !== 1'b1) begin
         miss++; $display("FAIL skip_end: cw=%b ready=%b want 0/1", compute_write, aw_ready);
      end
   endtask

   task automatic test_digit_loop();
      int exp_seq[6] = '{4, 4, 3, 4, 4, 2};
      int k = 0;
      for (int i = 0; i < SIMD; i++) drive(1, (i == 0), 0, 1, 0, 0, 0);
      for (int a = 0; a < 2; a++) begin
         for (int w = 0; w < 3; w++) begin
            drive(0, 0, 0, 1, (a == 1), (w == 2), 0);
            vec++;
            if (ctrl !== 3'(exp_seq[k]) || compute_write !== 1'b1) begin
               miss++; $display("FAIL digit_loop[%0d]: ctrl=%0d cw=%b want %0d/1", k, ctrl, compute_write, exp_seq[k]);
            end
            k++;
         end
      end
      drive(0, 0, 0, 1, 0, 0, 0);
      vec++;
      if (compute_write !== 1'b0 || aw_ready !== 1'b1) begin
         miss++; $display("FAIL digit_loop_end: cw=%b ready=%b want 0/1", compute_write, aw_ready);
      end
   endtask

   task automatic test_empty_window();
      for (int i = 0; i < SIMD; i++) begin
         drive(1, 0, (i == SIMD - 1), 1, 0, 0, 0);
         vec++;
         if (ctrl !== 3'd0 || aw_ready !== 1'b1) begin
            miss++; $display("FAIL empty_load[%0d]: ctrl=%0d ready=%b want 0/1", i, ctrl, aw_ready);
         end
      end
      m_commit();
      drive(0, 0, 0, 1, 0, 0, 0);
      vec++;
      if (acc_sel !== SEL_W'(m_acc_sel) || drain_req !== 1'b1 || drain_bank !== SEL_W'(bank_q[0])) begin
         miss++; $display("FAIL empty_commit: acc_sel=%0d req=%b bank=%0d want %0d/1/%0d",
                          acc_sel, drain_req, drain_bank, m_acc_sel, bank_q[0]);
      end
      drive(0, 0, 0, 1, 0, 0, 1);
      m_ack();
      drive(0, 0, 0, 1, 0, 0, 0);
      vec++;
      if (drain_req !== 1'b0) begin miss++; $display("FAIL empty_drained: req=%b want 0", drain_req); end
   endtask

   task automatic test_bank_stall();
      // Window 1: empty, eow on last beat -> commit in LOAD.
      for (int i = 0; i < SIMD; i++) drive(1, 0, (i == SIMD - 1), 1, 1, 1, 0);
      m_commit();
      // Window 2: dense, eow on first beat -> commit at end of compute, banks full.
      for (int i = 0; i < SIMD; i++) drive(1, 1, (i == 0), 0, 1, 1, 0);
      for (int i = 0; i < SIMD; i++) drive(0, 0, 0, 0, 1, 1, 0);
      m_commit();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 1, 1, 0);
         vec++;
         if (aw_ready !== 1'b0 || ctrl !== 3'd0 || compute_write !== 1'b0 ||
             drain_req !== 1'b1 || drain_bank !== SEL_W'(bank_q[0])) begin
            miss++; $display("FAIL stall[%0d]: ready=%b ctrl=%0d cw=%b req=%b bank=%0d want 0/0/0/1/%0d",
                             i, aw_ready, ctrl, compute_write, drain_req, drain_bank, bank_q[0]);
         end
      end
      drive(0, 0, 0, 0, 1, 1, 1);
      m_ack();
      drive(0, 0, 0, 0, 1, 1, 0);
      vec++;
      if (aw_ready !== 1'b1 || drain_bank !== SEL_W'(bank_q[0])) begin
         miss++; $display("FAIL stall_release: ready=%b bank=%0d want 1/%0d", aw_ready, drain_bank, bank_q[0]);
      end
      // Commit and ack on the same edge: pending count stays put.
      for (int i = 0; i < SIMD; i++) drive(1, 0, (i == SIMD - 1), 1, 1, 1, (i == SIMD - 1));
      m_ack();
      m_commit();
      drive(0, 0, 0, 1, 1, 1, 0);
      vec++;
      if (drain_req !== 1'b1 || drain_bank !== SEL_W'(bank_q[0]) || acc_sel !== SEL_W'(m_acc_sel) || aw_ready !== 1'b1) begin
         miss++; $display("FAIL commit_and_ack: req=%b bank=%0d sel=%0d ready=%b want 1/%0d/%0d/1",
                          drain_req, drain_bank, acc_sel, aw_ready, bank_q[0], m_acc_sel);
      end
      drive(0, 0, 0, 1, 1, 1, 1);
      m_ack();
      drive(0, 0, 0, 1, 1, 1, 0);
      vec++;
      if (drain_req !== 1'b0) begin miss++; $display("FAIL stall_drained: req=%b want 0", drain_req); end
   endtask

   task automatic test_cap_reset();
      int ec;
      // One stored pair, last-digit flags never asserted: full 4x4 loop.
      for (int i = 0; i < SIMD; i++) drive(1, (i == 1), 0, 1, 0, 0, 0);
      for (int a = 0; a < A_DIGITS; a++) begin
         for (int w = 0; w < W_DIGITS; w++) begin
            ec = (w < W_DIGITS - 1) ? 4 : (a < A_DIGITS - 1) ? 3 : 2;
            drive(0, 0, 0, 1, 0, 0, 0);
            vec++;
            if (ctrl !== 3'(ec) || compute_write !== 1'b1) begin
               miss++; $display("FAIL cap[%0d,%0d]: ctrl=%0d cw=%b want %0d/1", a, w, ctrl, compute_write, ec);
            end
         end
      end
      drive(0, 0, 0, 1, 0, 0, 0);
      vec++;
      if (compute_write !== 1'b0) begin miss++; $display("FAIL cap_end: cw=%b want 0", compute_write); end
      // Leave a bank pending, start another capped pair, then reset mid-compute.
      for (int i = 0; i < SIMD; i++) drive(1, 0, (i == SIMD - 1), 1, 0, 0, 0);
      m_commit();
      for (int i = 0; i < SIMD; i++) drive(1, (i == 0), 0, 1, 0, 0, 0);
      for (int c = 0; c < 7; c++) drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_acc_sel = 0;
      bank_q.delete();
      drive(0, 0, 0, 1, 0, 0, 0);
      vec++;
      if (aw_ready !== 1'b1 || ctrl !== 3'd0 || compute_write !== 1'b0 ||
          drain_req !== 1'b0 || acc_sel !== '0) begin
         miss++; $display("FAIL reset_mid_compute: ready=%b ctrl=%0d cw=%b req=%b sel=%0d want 1/0/0/0/0",
                          aw_ready, ctrl, compute_write, drain_req, acc_sel);
      end
   endtask

   task automatic test_random_windows(input int n_win);
      for (int wi = 0; wi < n_win; wi++) begin
         bit skip, win_eow, acc_b, st, exp_rdy, al, wl;
         int beats, stored, guard, ec, na, nw;
         skip    = 1'($urandom_range(0, 1));
         win_eow = 1'b0;
         beats   = 0;
         stored  = 0;
         guard   = 0;
         // Load phase: SIMD accepted beats.
         while (beats < SIMD) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
                  skip, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
            exp_rdy = (bank_q.size() < NUM_ACC);
            acc_b   = aw_valid && exp_rdy;
            st      = acc_b && (nz || !skip);
            vec++;
            if (aw_ready !== exp_rdy || ctrl !== (st ? 3'd1 : 3'd0) || compute_write !== 1'b0) begin
               miss++; $display("FAIL rnd_load w%0d: ready=%b ctrl=%0d cw=%b want %b/%0d/0",
                                wi, aw_ready, ctrl, compute_write, exp_rdy, st);
            end
            vec++;
            if (drain_req !== (bank_q.size() != 0) || acc_sel !== SEL_W'(m_acc_sel) ||
                (bank_q.size() != 0 && drain_bank !== SEL_W'(bank_q[0]))) begin
               miss++; $display("FAIL rnd_load_banks w%0d: req=%b sel=%0d bank=%0d want %b/%0d/%0d",
                                wi, drain_req, acc_sel, drain_bank, (bank_q.size() != 0), m_acc_sel,
                                (bank_q.size() != 0) ? bank_q[0] : -1);
            end
            if (drain_ack) m_ack();
            if (acc_b) begin
               beats++;
               if (st) stored++;
               if (eow) win_eow = 1'b1;
               if (beats == SIMD && stored == 0 && win_eow) m_commit();
            end
            guard++;
            if (guard > 300) begin
               vec++; miss++; $display("FAIL rnd_load_timeout w%0d: beats=%0d want %0d", wi, beats, SIMD);
               break;
            end
         end
         // Compute phase: digit loop per stored pair.
         for (int p = 0; p < stored; p++) begin
            na = $urandom_range(1, A_DIGITS);
            nw = $urandom_range(1, W_DIGITS);
            for (int a = 0; a < na; a++) begin
               for (int w = 0; w < nw; w++) begin
                  // At the cap the flag may stay low; the digit limit must end the loop.
                  al = (a == na - 1) && !(na == A_DIGITS && $urandom_range(0, 1) == 1);
                  wl = (w == nw - 1) && !(nw == W_DIGITS && $urandom_range(0, 1) == 1);
                  ec = (w < nw - 1) ? 4 : (a < na - 1) ? 3 : 2;
                  drive(1'($urandom), 1'($urandom), 1'($urandom), skip, al, wl, ($urandom_range(0, 2) == 0));
                  vec++;
                  if (ctrl !== 3'(ec) || compute_write !== 1'b1 || aw_ready !== 1'b0) begin
                     miss++; $display("FAIL rnd_compute w%0d p%0d a%0d w%0d: ctrl=%0d cw=%b ready=%b want %0d/1/0",
                                      wi, p, a, w, ctrl, compute_write, aw_ready, ec);
                  end
                  vec++;
                  if (drain_req !== (bank_q.size() != 0) ||
                      (bank_q.size() != 0 && drain_bank !== SEL_W'(bank_q[0]))) begin
                     miss++; $display("FAIL rnd_compute_banks w%0d: req=%b bank=%0d", wi, drain_req, drain_bank);
                  end
                  if (drain_ack) m_ack();
                  if (p == stored - 1 && a == na - 1 && w == nw - 1 && win_eow) m_commit();
               end
            end
         end
         // All banks committed after compute: wait for a drain.
         guard = 0;
         while (stored > 0 && bank_q.size() == NUM_ACC) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), skip, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 1));
            vec++;
            if (aw_ready !== 1'b0 || ctrl !== 3'd0 || compute_write !== 1'b0 ||
                drain_req !== 1'b1 || drain_bank !== SEL_W'(bank_q[0])) begin
               miss++; $display("FAIL rnd_stall w%0d: ready=%b ctrl=%0d cw=%b req=%b bank=%0d want 0/0/0/1/%0d",
                                wi, aw_ready, ctrl, compute_write, drain_req, drain_bank, bank_q[0]);
            end
            if (drain_ack) m_ack();
            guard++;
            if (guard > 300) begin
               vec++; miss++; $display("FAIL rnd_stall_timeout w%0d", wi);
               break;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_dense();
      test_skip();
      test_digit_loop();
      test_empty_window();
      test_bank_stall();
      test_cap_reset();
      test_random_windows(60);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
